// File: rtl/pipe_pkg.sv
// Shared constants for inter-stage pipeline registers: occupancy encoding and per-stage bus widths.
// Used by pipe_slot and pipe_stage_reg (build option PIPE_SKID_EN lives in pipe_stage_reg).
package pipe_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Payload field widths shared by the core stages.
   localparam int ADDR_BUS_WIDTH     = 32;
   localparam int DATA_BUS_WIDTH     = 32;
   localparam int INSN_BUS_WIDTH     = 32;
   localparam int MEM_SEL_BUS_WIDTH  = 4;
   localparam int MEM_OP_BUS_WIDTH   = 2;
   localparam int REG_ADDR_BUS_WIDTH = 5;
   localparam int ALU_OP_BUS_WIDTH   = 4;
   localparam int CTRL_OP_BUS_WIDTH  = 2;
   localparam int EXP_CODE_WIDTH     = 3;

   function automatic occ_e occ_count(input logic m_valid, input logic s_valid);
      occ_e occ;
      if (m_valid && s_valid) begin
         occ = OCC_FULL;
      end else if (m_valid || s_valid) begin
         occ = OCC_ONE;
      end else begin
         occ = OCC_EMPTY;
      end
      return occ;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One-entry valid+data register. Priority inside the slot: reset > flush > load > clear.
// Flush keeps bits marked in FLUSH_KEEP_MASK and returns the rest to RESET_VALUE.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int               WIDTH           = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
   parameter logic [WIDTH-1:0] FLUSH_KEEP_MASK = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         data_d  = (data_q & FLUSH_KEEP_MASK) | (RESET_VALUE & ~FLUSH_KEEP_MASK);
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (clear) begin
         // Data is left in place so the outputs stay quiet on a bubble.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VALUE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and masked flush.
// Define PIPE_SKID_EN for the two-entry build whose in_ready is purely registered.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid must hold with stable data until it transfers, ready may change freely.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH           = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] FLUSH_KEEP_MASK = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic             in_fire;
   logic             stall;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_load;
   logic             m_clear;
   logic [WIDTH-1:0] m_load_data;

   assign in_fire = in_valid && in_ready;
   assign stall   = m_valid && !out_ready;

   pipe_slot #(
      .WIDTH           (WIDTH),
      .RESET_VALUE     (RESET_VALUE),
      .FLUSH_KEEP_MASK (FLUSH_KEEP_MASK)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (m_load),
      .clear     (m_clear),
      .load_data (m_load_data),
      .valid     (m_valid),
      .data      (m_data)
   );

`ifdef PIPE_SKID_EN
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_load;
   logic             s_clear;

   // Skid occupancy alone gates the upstream, so no path from out_ready to in_ready.
   assign in_ready = !s_valid;

   always_comb begin
      m_load      = 1'b0;
      m_clear     = 1'b0;
      m_load_data = in_data;
      s_load      = 1'b0;
      s_clear     = 1'b0;
      if (!stall) begin
         if (s_valid) begin
            m_load      = 1'b1;
            m_load_data = s_data;
            s_clear     = 1'b1;
         end else if (in_fire) begin
            m_load = 1'b1;
         end else begin
            m_clear = 1'b1;
         end
      end else if (in_fire) begin
         s_load = 1'b1;
      end
   end

   pipe_slot #(
      .WIDTH           (WIDTH),
      .RESET_VALUE     (RESET_VALUE),
      .FLUSH_KEEP_MASK (FLUSH_KEEP_MASK)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (s_load),
      .clear     (s_clear),
      .load_data (in_data),
      .valid     (s_valid),
      .data      (s_data)
   );

   assign occupancy = occ_count(m_valid, s_valid);
`else
   // Legacy single-slot behaviour: accept whenever the held entry leaves this cycle.
   assign in_ready = !m_valid || out_ready;

   always_comb begin
      m_load      = 1'b0;
      m_clear     = 1'b0;
      m_load_data = in_data;
      if (in_fire) begin
         m_load = 1'b1;
      end else if (!stall) begin
         m_clear = 1'b1;
      end
   end

   assign occupancy = occ_count(m_valid, 1'b0);
`endif

   assign out_valid = m_valid;
   assign out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; skid scenarios are selected with PIPE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH           (32),
    .RESET_VALUE     (32'h0000_0000),
    .FLUSH_KEEP_MASK (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h exp 00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d exp 0", occupancy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h exp a5a50001", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d exp 1", occupancy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'(i - 1)) begin
          errors++; $display("FAIL b2b_out[%0d]: got v=%b d=%h exp v=1 d=%h", i - 1, out_valid, out_data, 32'(i - 1));
        end
      end
      if (i <= 8) begin
        in_valid = 1'b1; in_data = 32'(i);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL b2b_empty: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  // One held entry, output still flowing: the same-cycle input is accepted then dropped.
  task automatic test_flush_one();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'h0000_0099; out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush1_in_ready: got %b exp 1", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush1_empty: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    checks++; if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL flush1_data: got %h exp 12340000", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_no_99: got v=%b d=%h exp v=0", out_valid, out_data); end
  endtask

`ifdef PIPE_SKID_EN
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = a;
    @(negedge clk);
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_skid();
    exp_q.delete();
    exp_q.push_back(32'h10); exp_q.push_back(32'h11); exp_q.push_back(32'h12);
    fill_two(32'h10, 32'h11);
    in_valid = 1'b1; in_data = 32'h12;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ: got %0d exp 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (occupancy !== 2'd2 || out_data !== 32'h10) begin errors++; $display("FAIL skid_hold: got occ=%0d d=%h exp occ=2 d=00000010", occupancy, out_data); end
    out_ready = 1'b1;
    for (int n = 0; n < 6 && exp_q.size() > 0; n++) begin
      @(posedge clk);
      if (out_valid && out_ready) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (out_data !== e) begin errors++; $display("FAIL skid_order: got %h exp %h", out_data, e); end
      end
      if (in_valid && in_ready) in_valid <= 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL skid_lost: got %0d left exp 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL skid_empty: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush_two();
    fill_two(32'h1234_5678, 32'hABCD_EF01);
    in_valid = 1'b1; in_data = 32'h0000_0099; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush2_empty: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    checks++; if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL flush2_data: got %h exp 12340000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush2_in_ready: got %b exp 1", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_no_99: got v=%b d=%h exp v=0", out_valid, out_data); end
  endtask

  task automatic test_reset_stall();
    fill_two(32'hDEAD_0001, 32'hDEAD_0002);
    in_valid = 1'b1; in_data = 32'hDEAD_0003; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst2_out: got v=%b d=%h exp v=0 d=00000000", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL rst2_state: got rdy=%b occ=%0d exp rdy=1 occ=0", in_ready, occupancy); end
  endtask
`else
  task automatic test_stall_bubble();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    @(negedge clk);
    in_data = 32'h66;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nsk_in_ready_stall: got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin errors++; $display("FAIL nsk_hold: got v=%b d=%h exp v=1 d=00000055", out_valid, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nsk_in_ready_comb: got %b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL nsk_bubble: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_reset_stall();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_0001;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst1_out: got v=%b d=%h exp v=0 d=00000000", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL rst1_state: got rdy=%b occ=%0d exp rdy=1 occ=0", in_ready, occupancy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush_one();
`ifdef PIPE_SKID_EN
    test_skid();
    test_flush_two();
    test_reset_stall();
`else
    test_stall_bubble();
    test_reset_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
